qrs_peak_detector: RTL and testbench
====================================

Name: qrs_peak_detector

Overview:
- Decision stage directly downstream of the Pan-Tompkins filter chain (`top`).
- Consumes the moving-window-integrated signal `y` one sample per enabled clock.
- Finds local peaks and classifies each as QRS or noise using adaptive signal/noise levels, with a refractory lockout.
- Emits a one-cycle QRS pulse plus the R-R interval in samples.

Parameters:
- DATA_WIDTH, 16, width of the signed input sample.
- CNT_WIDTH, 16, width of the sample counter and `rr_interval`.
- LEARN_LEN, 400, number of enabled samples in the initial learning window (2 s at 200 Hz).
- REFRACT, 40, minimum samples after a QRS before a new peak is eligible (200 ms at 200 Hz).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  sample enable; `xin` is valid and consumed on each rising clk edge with en=1.
- xin  input  DATA_WIDTH  signed integrated ECG sample (`y` from `top`).
- qrs_detect  output  1  one-cycle pulse, QRS decision.
- rr_interval  output  CNT_WIDTH  samples between the last two QRS decisions.
- rr_valid  output  1  high once two QRS decisions have occurred.
- threshold  output  DATA_WIDTH  current detection threshold THR.
- learning  output  1  high while in LEARN state.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset `rstn` is asynchronous, active-low.
  - All outputs and state are registered.
- Reset values:
  - state=LEARN, learning=1.
  - qrs_detect=0, rr_interval=0, rr_valid=0, threshold=0.
  - SPKI=NPKI=0, x1=x2=0, learn_cnt=0, learn_max=0, since_qrs=0.
- Input clamp:
  - xc = 0 if xin<0, else xin.
  - All level arithmetic is unsigned on DATA_WIDTH-1 bits, with one extra guard bit internally.
  - No result may wrap.
- Sample handling:
  - Nothing changes on clocks with en=0.
  - qrs_detect is also forced 0 on those clocks.
  - History shift on every en=1 sample: x2<=x1, x1<=xc.
- Peak candidate:
  - Evaluated on each en=1 sample using the values before the shift.
  - Condition: x1>x2 && x1>=xc && x1>0; P=x1.
  - Plateaus count once, at their first sample.
- LEARN state:
  - Each en=1 sample: learn_max<=max(learn_max,xc), learn_cnt++.
  - On the LEARN_LEN-th sample, move to DETECT.
  - SPKI<=learn_max>>1 and NPKI<=learn_max>>3, both computed with that sample's xc included.
  - since_qrs<=all-ones.
  - No detections while in LEARN; learning drops in the same cycle.
- DETECT state, every en=1 sample:
  - A peak is eligible when since_qrs>=REFRACT.
  - Eligible peak with P>THR:
    - QRS decision: qrs_detect=1 for exactly the next clock.
    - SPKI<=SPKI-(SPKI>>3)+(P>>3).
    - rr_interval<=since_qrs+1, saturating at all-ones.
    - rr_valid<=1 from the second decision onward.
    - since_qrs<=0.
  - Eligible peak with P<=THR: NPKI<=NPKI-(NPKI>>3)+(P>>3).
  - Otherwise: since_qrs<=since_qrs+1, saturating.
  - Peaks inside the refractory window are ignored and do not update NPKI.
- Threshold:
  - THR = NPKI+((SPKI-NPKI)>>2), using 0 if SPKI<NPKI.
  - Recomputed combinationally from the registered levels and presented on `threshold` registered.
  - Compares always use the THR from before the current update.
- Latency:
  - A peak at sample n (x1) is decided when sample n+1 is clocked in.
  - qrs_detect is high during the clock cycle after that edge.
- Reset mid-operation:
  - Immediately returns every register to its reset value.
  - Learning restarts from zero.
- State machine:
  - LEARN -> DETECT on learn completion only.
  - DETECT is held until reset.

Test Plan:
- Reset/idle: rstn=0 with random xin, then en=0 for 20 clocks.
  - Required: all outputs at reset values, learning=1.
- Learning: LEARN_LEN=8, REFRACT=4; samples 0,100,800,100,0,0,0,0.
  - Required: learning falls after the 8th sample.
  - Required: SPKI=400, NPKI=100, threshold=175.
  - Required: no qrs_detect during LEARN.
- Detection: after the above, feed 0,1000,0.
  - Required: qrs_detect pulses once, one clock after the 0 following 1000.
  - Required: SPKI=475, threshold=193.
  - Required: rr_valid stays 0.
- Noise peak: feed isolated peak 150 after 10 zeros.
  - Required: no pulse.
  - Required: NPKI=100-12+18=106, threshold=106+((475-106)>>2)=198.
- Refractory and R-R: peak 1000, then peak 1000 two samples later, then peak 1000 fifty samples after the first.
  - Required: second peak ignored, with no NPKI change.
  - Required: third peak detected, rr_interval=50, rr_valid=1.
- Plateau/negatives/saturation: plateau 900,900,900 gives one detection; xin=-500 is treated as 0; 70000 zero samples hold since_qrs at 65535, so the next QRS gives rr_interval=65535.
  - Required: assert rstn low mid-sequence and confirm an immediate return to LEARN.

Source files
------------

// File: rtl/qrs_peak_detector.sv
// QRS decision stage for the Pan-Tompkins chain.
// It takes the moving-window-integrated signal one sample per enabled clock.
// A short learning window seeds the signal and noise levels.
// After that, each local peak is classified against an adaptive threshold,
// and a refractory lockout follows every QRS decision.
module qrs_peak_detector #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int LEARN_LEN  = 400,
    parameter int REFRACT    = 40
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] xin,
    output logic                  qrs_detect,
    output logic [CNT_WIDTH-1:0]  rr_interval,
    output logic                  rr_valid,
    output logic [DATA_WIDTH-1:0] threshold,
    output logic                  learning
);

    // Levels live on the magnitude bits only (the input is clamped non-negative).
    localparam int LW  = DATA_WIDTH - 1;
    localparam int LCW = (LEARN_LEN > 1) ? $clog2(LEARN_LEN + 1) : 1;

    typedef enum logic {
        S_LEARN  = 1'b0,
        S_DETECT = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [LW-1:0]          x1_reg, x1_next;
    logic [LW-1:0]          x2_reg, x2_next;
    logic [LW-1:0]          spki_reg, spki_next;
    logic [LW-1:0]          npki_reg, npki_next;
    logic [LW-1:0]          learn_max_reg, learn_max_next;
    logic [LCW-1:0]         learn_cnt_reg, learn_cnt_next;
    logic [CNT_WIDTH-1:0]   since_qrs_reg, since_qrs_next;
    logic [CNT_WIDTH-1:0]   rr_interval_reg, rr_interval_next;
    logic                   rr_valid_reg, rr_valid_next;
    logic                   seen_qrs_reg, seen_qrs_next;
    logic                   qrs_detect_reg, qrs_detect_next;
    logic [DATA_WIDTH-1:0]  threshold_reg, threshold_next;

    logic [LW-1:0]          xc;
    logic [LW-1:0]          lmax_new;
    logic [LW-1:0]          thr_cur;
    logic [CNT_WIDTH-1:0]   since_inc;
    logic                   peak;
    logic                   eligible;

    // THR = NPKI + (SPKI-NPKI)/4, with the difference floored at zero.
    // The result never exceeds max(SPKI, NPKI), so it cannot wrap.
    function automatic logic [LW-1:0] thr_of(input logic [LW-1:0] s, input logic [LW-1:0] n);
        logic [LW-1:0] diff;
        diff = (s > n) ? (s - n) : '0;
        return n + (diff >> 2);
    endfunction

    // Exponential level update: L - L/8 + P/8, evaluated with a guard bit.
    function automatic logic [LW-1:0] level_upd(input logic [LW-1:0] l, input logic [LW-1:0] p);
        logic [LW:0] acc;
        acc = {1'b0, l} - ({1'b0, l} >> 3) + ({1'b0, p} >> 3);
        return acc[LW-1:0];
    endfunction

    // Next-state, datapath and output decisions for one enabled sample.
    always_comb begin
        state_next       = state_reg;
        x1_next          = x1_reg;
        x2_next          = x2_reg;
        spki_next        = spki_reg;
        npki_next        = npki_reg;
        learn_max_next   = learn_max_reg;
        learn_cnt_next   = learn_cnt_reg;
        since_qrs_next   = since_qrs_reg;
        rr_interval_next = rr_interval_reg;
        rr_valid_next    = rr_valid_reg;
        seen_qrs_next    = seen_qrs_reg;
        qrs_detect_next  = 1'b0;

        xc        = xin[DATA_WIDTH-1] ? '0 : xin[LW-1:0];
        lmax_new  = (xc > learn_max_reg) ? xc : learn_max_reg;
        thr_cur   = thr_of(spki_reg, npki_reg);
        since_inc = (since_qrs_reg == '1) ? since_qrs_reg : since_qrs_reg + 1'b1;
        // Strict rise then non-strict fall: a plateau triggers only on its first sample.
        peak      = (x1_reg > x2_reg) && (x1_reg >= xc) && (x1_reg != '0);
        eligible  = peak && (since_qrs_reg >= CNT_WIDTH'(REFRACT));

        if (en) begin
            x2_next = x1_reg;
            x1_next = xc;
            if (state_reg == S_LEARN) begin
                learn_max_next = lmax_new;
                learn_cnt_next = learn_cnt_reg + 1'b1;
                if (learn_cnt_reg == LCW'(LEARN_LEN - 1)) begin
                    state_next     = S_DETECT;
                    spki_next      = lmax_new >> 1;
                    npki_next      = lmax_new >> 3;
                    since_qrs_next = '1;
                end
            end else begin
                since_qrs_next = since_inc;
                if (eligible) begin
                    if (x1_reg > thr_cur) begin
                        qrs_detect_next  = 1'b1;
                        spki_next        = level_upd(spki_reg, x1_reg);
                        rr_interval_next = since_inc;
                        rr_valid_next    = seen_qrs_reg;
                        seen_qrs_next    = 1'b1;
                        since_qrs_next   = '0;
                    end else begin
                        npki_next = level_upd(npki_reg, x1_reg);
                    end
                end
            end
        end

        threshold_next = {1'b0, thr_of(spki_next, npki_next)};
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_LEARN;
            x1_reg          <= '0;
            x2_reg          <= '0;
            spki_reg        <= '0;
            npki_reg        <= '0;
            learn_max_reg   <= '0;
            learn_cnt_reg   <= '0;
            since_qrs_reg   <= '0;
            rr_interval_reg <= '0;
            rr_valid_reg    <= 1'b0;
            seen_qrs_reg    <= 1'b0;
            qrs_detect_reg  <= 1'b0;
            threshold_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            x1_reg          <= x1_next;
            x2_reg          <= x2_next;
            spki_reg        <= spki_next;
            npki_reg        <= npki_next;
            learn_max_reg   <= learn_max_next;
            learn_cnt_reg   <= learn_cnt_next;
            since_qrs_reg   <= since_qrs_next;
            rr_interval_reg <= rr_interval_next;
            rr_valid_reg    <= rr_valid_next;
            seen_qrs_reg    <= seen_qrs_next;
            qrs_detect_reg  <= qrs_detect_next;
            threshold_reg   <= threshold_next;
        end
    end

    assign qrs_detect  = qrs_detect_reg;
    assign rr_interval = rr_interval_reg;
    assign rr_valid    = rr_valid_reg;
    assign threshold   = threshold_reg;
    assign learning    = (state_reg == S_LEARN);

endmodule

// File: tb/tb_qrs_peak_detector.sv
// Self-checking bench for qrs_peak_detector with a short learning window.
// A sample-indexed reference model tracks levels, peaks and R-R distances.
module tb_qrs_peak_detector;

    localparam int LL  = 8;
    localparam int RF  = 4;
    localparam int MAXC = 65535;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] xin;
    logic        qrs_detect;
    logic [15:0] rr_interval;
    logic        rr_valid;
    logic [15:0] threshold;
    logic        learning;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state: everything is indexed by enabled-sample number.
    bit m_learning;
    int m_lcnt, m_lmax, m_spki, m_npki;
    int h1, h2, n, lastq, m_dec, m_rr;
    bit have_q, m_rrv, m_qrs;

    qrs_peak_detector #(
        .DATA_WIDTH(16), .CNT_WIDTH(16), .LEARN_LEN(LL), .REFRACT(RF)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .xin(xin),
        .qrs_detect(qrs_detect), .rr_interval(rr_interval), .rr_valid(rr_valid),
        .threshold(threshold), .learning(learning)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_thr(input int s, input int nn);
        return nn + ((s > nn) ? (s - nn) / 4 : 0);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_learning = 1; m_lcnt = 0; m_lmax = 0; m_spki = 0; m_npki = 0;
        h1 = 0; h2 = 0; n = 0; lastq = 0; m_dec = 0; m_rr = 0;
        have_q = 0; m_rrv = 0; m_qrs = 0;
    endtask

    task automatic model_sample(input int x, input bit e);
        int c, thr, since;
        m_qrs = 0;
        if (e) begin
            c = (x < 0) ? 0 : x;
            if (m_learning) begin
                if (c > m_lmax) m_lmax = c;
                m_lcnt++;
                if (m_lcnt == LL) begin
                    m_learning = 0;
                    m_spki = m_lmax / 2;
                    m_npki = m_lmax / 8;
                    have_q = 0;
                end
            end else begin
                thr   = m_thr(m_spki, m_npki);
                since = have_q ? imin(n - lastq - 1, MAXC) : MAXC;
                if (h1 > h2 && h1 >= c && h1 > 0 && since >= RF) begin
                    if (h1 > thr) begin
                        m_qrs  = 1;
                        m_spki = m_spki - m_spki / 8 + h1 / 8;
                        m_rr   = imin(since + 1, MAXC);
                        m_dec++;
                        m_rrv  = (m_dec >= 2);
                        lastq  = n;
                        have_q = 1;
                    end else begin
                        m_npki = m_npki - m_npki / 8 + h1 / 8;
                    end
                end
            end
            h2 = h1;
            h1 = c;
            n++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_qrs"}, int'(qrs_detect), int'(m_qrs));
        chk({tag, "_learn"}, int'(learning), int'(m_learning));
        chk({tag, "_thr"}, int'(threshold), m_thr(m_spki, m_npki));
        chk({tag, "_rr"}, int'(rr_interval), m_rr);
        chk({tag, "_rrv"}, int'(rr_valid), int'(m_rrv));
    endtask

    // One clock with the given sample; outputs are checked 1 time unit after the edge.
    task automatic step(input int x, input bit e, input bit do_chk, input string tag);
        xin = 16'(x);
        en  = e;
        @(posedge clk);
        #1;
        model_sample(x, e);
        if (qrs_detect) pulses++;
        if (do_chk) check_outputs(tag);
    endtask

    task automatic zeros(input int cnt, input bit do_chk);
        for (int i = 0; i < cnt; i++) step(0, 1'b1, do_chk, "zero");
    endtask

    initial begin
        int p0, x, v;
        model_reset();
        rstn = 1'b0;
        en   = 1'b1;
        xin  = 16'($urandom);

        // Reset held with random traffic, then 20 idle clocks.
        for (int i = 0; i < 3; i++) begin
            xin = 16'($urandom);
            @(posedge clk);
        end
        #1;
        check_outputs("in_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) step(int'($urandom_range(0, 3000)), 1'b0, 1'b1, "idle");
        chk("idle_spki", int'(dut.spki_reg), 0);
        chk("idle_npki", int'(dut.npki_reg), 0);

        // Learning window.
        step(0, 1, 1, "learn"); step(100, 1, 1, "learn"); step(800, 1, 1, "learn");
        step(100, 1, 1, "learn"); step(0, 1, 1, "learn"); step(0, 1, 1, "learn");
        step(0, 1, 1, "learn");
        chk("learn_still_high", int'(learning), 1);
        step(0, 1, 1, "learn_last");
        chk("learn_dropped", int'(learning), 0);
        chk("learn_spki", int'(dut.spki_reg), 400);
        chk("learn_npki", int'(dut.npki_reg), 100);
        chk("learn_thr", int'(threshold), 175);
        chk("learn_no_pulse", pulses, 0);

        // First detection.
        step(0, 1, 1, "det"); step(1000, 1, 1, "det");
        chk("det_before", int'(qrs_detect), 0);
        step(0, 1, 1, "det");
        chk("det_pulse", int'(qrs_detect), 1);
        chk("det_spki", int'(dut.spki_reg), 475);
        chk("det_thr", int'(threshold), 193);
        chk("det_rrv", int'(rr_valid), 0);
        step(0, 1, 1, "det_after");
        chk("det_pulse_once", pulses, 1);

        // Noise peak.
        zeros(10, 1);
        step(150, 1, 1, "noise"); step(0, 1, 1, "noise");
        chk("noise_no_pulse", pulses, 1);
        chk("noise_npki", int'(dut.npki_reg), 106);
        chk("noise_thr", int'(threshold), 198);

        // Refractory lockout and R-R interval.
        step(1000, 1, 1, "rr"); step(0, 1, 1, "rr");
        chk("rr_first", int'(qrs_detect), 1);
        step(1000, 1, 1, "rr"); step(0, 1, 1, "rr");
        chk("rr_locked", int'(qrs_detect), 0);
        chk("rr_locked_npki", int'(dut.npki_reg), 106);
        zeros(46, 1);
        step(1000, 1, 1, "rr"); step(0, 1, 1, "rr");
        chk("rr_third", int'(qrs_detect), 1);
        chk("rr_interval", int'(rr_interval), 50);
        chk("rr_valid", int'(rr_valid), 1);

        // Plateau counts once.
        zeros(6, 1);
        p0 = pulses;
        step(900, 1, 1, "plat"); step(900, 1, 1, "plat"); step(900, 1, 1, "plat");
        step(0, 1, 1, "plat"); zeros(6, 1);
        chk("plateau_pulses", pulses - p0, 1);

        // Negative input is clamped to zero.
        step(1000, 1, 1, "neg"); step(-500, 1, 1, "neg");
        chk("neg_clamp_pulse", int'(qrs_detect), 1);
        step(-500, 1, 1, "neg"); step(-32768, 1, 1, "neg");

        // Saturation of the sample counter.
        zeros(70000, 0);
        step(1000, 1, 1, "sat"); step(0, 1, 1, "sat");
        chk("sat_pulse", int'(qrs_detect), 1);
        chk("sat_rr", int'(rr_interval), 65535);

        // Randomized traffic with sparse peaks and gaps in en.
        for (int i = 0; i < 400; i++) begin
            v = int'($urandom_range(0, 9));
            x = (v < 6) ? int'($urandom_range(0, 200)) :
                (v < 8) ? int'($urandom_range(0, 3000)) - 500 : int'($urandom_range(0, 32767));
            step(x, ($urandom_range(0, 4) != 0), 1, "rand");
        end

        // Asynchronous reset in mid-operation.
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        chk("midrst_spki", int'(dut.spki_reg), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Learning restarts from zero, then more random traffic.
        for (int i = 0; i < 300; i++) begin
            x = int'($urandom_range(0, 4000)) - 300;
            step(x, ($urandom_range(0, 3) != 0), 1, "rand2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
